// File: rtl/if_id_stage.sv
// if_id_stage: program counter plus IF/ID pipeline register with stall, flush and redirect.
// Optional build macro HAZARD_CNT_EN adds saturating stall/flush cycle counters.
`default_nettype none

module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        keep_PC,
    input  logic        keep_IF_ID,
    input  logic        flush_IF_ID,
    input  logic        npc_op,
    input  logic [31:0] npc_target,
    input  logic [31:0] inst_IF,
    output logic [31:0] pc_IF,
    output logic [31:0] inst_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pc4_ID,
    output logic        valid_ID,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_inst_id;
    logic [31:0] r_pc_id;
    logic [31:0] r_pc4_id;
    logic        r_valid_id;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Redirect beats a load-use hold so a taken branch is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (npc_op) begin
            r_pc <= npc_target;
        end else if (!keep_PC) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_id  <= NOP_INST;
            r_pc_id    <= 32'h0;
            r_pc4_id   <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (flush_IF_ID) begin
            r_inst_id  <= NOP_INST;
            r_pc_id    <= 32'h0;
            r_pc4_id   <= 32'h0;
            r_valid_id <= 1'b0;
        end else if (!keep_IF_ID) begin
            r_inst_id  <= inst_IF;
            r_pc_id    <= r_pc;
            r_pc4_id   <= w_pc_plus4;
            r_valid_id <= 1'b1;
        end
    end

`ifdef HAZARD_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // A flush that coincides with a hold counts only as a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else begin
            if (flush_IF_ID) begin
                if (r_flush_cnt != 32'hFFFF_FFFF) begin
                    r_flush_cnt <= r_flush_cnt + 32'd1;
                end
            end else if (keep_IF_ID) begin
                if (r_stall_cnt != 32'hFFFF_FFFF) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

    assign pc_IF    = r_pc;
    assign inst_ID  = r_inst_id;
    assign pc_ID    = r_pc_id;
    assign pc4_ID   = r_pc4_id;
    assign valid_ID = r_valid_id;

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed stimulus against a cycle model of the fetch stage, plus literal spot checks.
`default_nettype none

module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic        keep_PC;
    logic        keep_IF_ID;
    logic        flush_IF_ID;
    logic        npc_op;
    logic [31:0] npc_target;
    logic [31:0] inst_IF;
    logic [31:0] pc_IF;
    logic [31:0] inst_ID;
    logic [31:0] pc_ID;
    logic [31:0] pc4_ID;
    logic        valid_ID;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

`ifdef HAZARD_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    if_id_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .keep_PC    (keep_PC),
        .keep_IF_ID (keep_IF_ID),
        .flush_IF_ID(flush_IF_ID),
        .npc_op     (npc_op),
        .npc_target (npc_target),
        .inst_IF    (inst_IF),
        .pc_IF      (pc_IF),
        .inst_ID    (inst_ID),
        .pc_ID      (pc_ID),
        .pc4_ID     (pc4_ID),
        .valid_ID   (valid_ID),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] irom(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign inst_IF = irom(pc_IF);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: expected state after each edge.
    logic [31:0] m_pc, m_inst, m_pc_id, m_pc4;
    logic        m_valid;
    longint      m_stall, m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_inst = 32'h13; m_pc_id = 0; m_pc4 = 0; m_valid = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            if (flush_IF_ID) begin
                m_inst = 32'h13; m_pc_id = 0; m_pc4 = 0; m_valid = 0;
                m_flush = (m_flush < 64'hFFFF_FFFF) ? m_flush + 1 : m_flush;
            end else if (keep_IF_ID) begin
                m_stall = (m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
            end else begin
                m_inst = irom(m_pc); m_pc_id = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1;
            end
            if (npc_op)        m_pc = npc_target;
            else if (!keep_PC) m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pc_IF",    pc_IF,    m_pc);
            chk("m_inst_ID",  inst_ID,  m_inst);
            chk("m_pc_ID",    pc_ID,    m_pc_id);
            chk("m_pc4_ID",   pc4_ID,   m_pc4);
            chk("m_valid_ID", {31'h0, valid_ID}, {31'h0, m_valid});
            chk("m_stall",    stall_cnt, CNT_ON ? m_stall[31:0] : 32'h0);
            chk("m_flush",    flush_cnt, CNT_ON ? m_flush[31:0] : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic kp, input logic kf, input logic fl,
                         input logic np, input logic [31:0] tg);
        keep_PC = kp; keep_IF_ID = kf; flush_IF_ID = fl; npc_op = np; npc_target = tg;
    endtask

    logic [3:0] pat [0:11];

    initial begin
        pat[0] = 4'b0000; pat[1] = 4'b0011; pat[2] = 4'b0000; pat[3] = 4'b0100;
        pat[4] = 4'b1100; pat[5] = 4'b0010; pat[6] = 4'b0001; pat[7] = 4'b0000;
        pat[8] = 4'b1000; pat[9] = 4'b0110; pat[10] = 4'b1111; pat[11] = 4'b0000;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        tick();
        tick();
        cmp_en = 1;
        chk("rst_pc_IF",   pc_IF,   32'h0);
        chk("rst_inst_ID", inst_ID, 32'h0000_0013);
        chk("rst_valid",   {31'h0, valid_ID}, 32'h0);

        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("seq_pc_IF", pc_IF, 32'(4 * k));
            chk("seq_pc_ID", pc_ID, 32'(4 * (k - 1)));
            chk("seq_inst",  inst_ID, irom(32'(4 * (k - 1))));
            chk("seq_valid", {31'h0, valid_ID}, 32'h1);
        end

        drive(1, 1, 0, 0, 32'h0);
        tick();
        tick();
        chk("stall_pc_IF", pc_IF, 32'h10);
        chk("stall_pc_ID", pc_ID, 32'h0C);
        chk("stall_cnt2",  stall_cnt, CNT_ON ? 32'd2 : 32'd0);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("resume_pc_IF", pc_IF, 32'h14);
        chk("resume_pc_ID", pc_ID, 32'h10);

        drive(0, 0, 1, 1, 32'h100);
        tick();
        chk("redir_pc_IF", pc_IF,   32'h100);
        chk("redir_inst",  inst_ID, 32'h0000_0013);
        chk("redir_valid", {31'h0, valid_ID}, 32'h0);
        chk("redir_pc_ID", pc_ID,   32'h0);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("after_pc_ID", pc_ID, 32'h100);
        chk("after_valid", {31'h0, valid_ID}, 32'h1);
        chk("flush_cnt1",  flush_cnt, CNT_ON ? 32'd1 : 32'd0);

        drive(1, 1, 1, 1, 32'h40);
        tick();
        chk("all_pc_IF",  pc_IF, 32'h40);
        chk("all_valid",  {31'h0, valid_ID}, 32'h0);
        chk("all_stall",  stall_cnt, CNT_ON ? 32'd2 : 32'd0);
        chk("all_flush",  flush_cnt, CNT_ON ? 32'd2 : 32'd0);

        for (int i = 0; i < 12; i++) begin
            drive(pat[i][3], pat[i][2], pat[i][1], pat[i][0], 32'h200 + 32'(i * 8));
            tick();
        end

        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pre", pc_IF, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("wrap_pc_IF",  pc_IF,  32'h0);
        chk("wrap_pc4_ID", pc4_ID, 32'h0);
        chk("wrap_pc_ID",  pc_ID,  32'hFFFF_FFFC);

        drive(1, 1, 0, 0, 32'h0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc_IF", pc_IF,   32'h0);
        chk("arst_inst",  inst_ID, 32'h0000_0013);
        chk("arst_pc4",   pc4_ID,  32'h0);
        chk("arst_valid", {31'h0, valid_ID}, 32'h0);
        chk("arst_stall", stall_cnt, 32'h0);
        chk("arst_flush", flush_cnt, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rel_pc_IF", pc_IF,   32'h4);
        chk("rel_inst",  inst_ID, irom(32'h0));
        chk("rel_valid", {31'h0, valid_ID}, 32'h1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 keep_PC  input  1  hold PC this cycle (load-use stall).
REQ-006 keep_IF_ID  input  1  hold IF/ID register this cycle.
REQ-007 flush_IF_ID  input  1  replace IF/ID contents with bubble.
REQ-008 npc_op  input  1  redirect taken; next PC = npc_target.
REQ-009 npc_target  input  32  redirect target address.
REQ-010 inst_IF  input  32  instruction fetched at pc_IF (combinational IROM output).
REQ-011 pc_IF  output  32  current fetch address (registered).
REQ-012 inst_ID  output  32  instruction in ID stage.
REQ-013 pc_ID  output  32  PC of inst_ID.
REQ-014 pc4_ID  output  32  pc_ID + 4.
REQ-015 valid_ID  output  1  1 = inst_ID is a real instruction, 0 = bubble.
REQ-016 stall_cnt  output  32  IF/ID stall-cycle count (see Configuration).
REQ-017 flush_cnt  output  32  IF/ID flush-cycle count (see Configuration).

Function
REQ-018 PC update per edge, priority order: npc_op -> pc_IF <= npc_target; else keep_PC -> hold; else pc_IF <= pc_IF + 4.
REQ-019 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000; npc_target used unaligned as given.
REQ-020 IF/ID update per edge, priority order: flush_IF_ID -> inst_ID <= NOP_INST, pc_ID <= 0, pc4_ID <= 0, valid_ID <= 0; else keep_IF_ID -> all IF/ID outputs hold; else inst_ID <= inst_IF, pc_ID <= pc_IF, pc4_ID <= pc_IF + 4, valid_ID <= 1.
REQ-021 Simultaneous npc_op and keep_PC: redirect wins; simultaneous flush_IF_ID and keep_IF_ID: flush wins.
REQ-022 Latency: instruction at pc_IF appears on inst_ID exactly one edge later when no keep/flush asserted.
REQ-023 keep held N cycles holds pc_IF and IF/ID for N edges; fetch resumes at held pc_IF on first edge after release (no instruction lost or duplicated).
REQ-024 No combinational path from any input to any output; all outputs are registers.

Reset
REQ-025 rst_n low asynchronously forces pc_IF = RESET_PC, inst_ID = NOP_INST, pc_ID = 0, pc4_ID = 0, valid_ID = 0, stall_cnt = 0, flush_cnt = 0.
REQ-026 Reset asserted mid-stall or mid-flush overrides all inputs immediately; no pending state survives.
REQ-027 First edge after rst_n release performs normal update: inst_ID <= inst_IF of RESET_PC, valid_ID <= 1, pc_IF <= RESET_PC + 4.

Configuration
REQ-028 Macro HAZARD_CNT_EN defined: stall_cnt increments on each edge with keep_IF_ID=1 and flush_IF_ID=0; flush_cnt increments on each edge with flush_IF_ID=1; both saturate at 32'hFFFF_FFFF.
REQ-029 HAZARD_CNT_EN undefined: no counter registers synthesised; stall_cnt and flush_cnt tied to 32'h0; all other behaviour identical.

Verification
REQ-030 Reset release, RESET_PC=0, IROM returns addr-based words, no hazards, 4 edges -> pc_IF 0,4,8,12,16; inst_ID/pc_ID track previous pc_IF; valid_ID=1 from edge 1.
REQ-031 pc_IF=0x10, keep_PC=keep_IF_ID=1 for 2 cycles -> pc_IF stays 0x10, inst_ID/pc_ID unchanged 2 edges, then pc_IF=0x14, pc_ID=0x10; stall_cnt=2 (counters built).
REQ-032 npc_op=1, npc_target=0x100, flush_IF_ID=1 for 1 cycle -> next edge pc_IF=0x100, inst_ID=0x00000013, valid_ID=0, pc_ID=0; following edge pc_ID=0x100, valid_ID=1; flush_cnt=1.
REQ-033 All of keep_PC, keep_IF_ID, npc_op, flush_IF_ID=1, npc_target=0x40 -> pc_IF=0x40, valid_ID=0, stall_cnt unchanged, flush_cnt +1.
REQ-034 pc_IF=0xFFFFFFFC, no hazards -> next pc_IF=0x0, pc4_ID=0x0; rst_n pulsed low between edges mid-stall -> outputs at reset values immediately, counters 0.
REQ-035 Build without HAZARD_CNT_EN, repeat REQ-031/032 -> identical pipeline outputs, stall_cnt=flush_cnt=0 throughout.
